// File: rtl/adder_pkg.sv
// Shared types for the sliced adder: FSM state, flag bundle and the
// elaboration-time slice/width consistency check.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } adder_state_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } adder_flags_t;

    function automatic bit slice_cfg_ok(input int width, input int slice);
        return (slice > 0) && (width >= slice) && ((width % slice) == 0);
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SLICE-bit ripple-carry adder built from fullAdder cells.
module adder_slice #(
    parameter int SLICE = 16
) (
    input  logic [SLICE-1:0] i_a,
    input  logic [SLICE-1:0] i_b,
    input  logic             i_cin,
    output logic [SLICE-1:0] o_sum,
    output logic             o_cout
);

    logic [SLICE:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar i = 0; i < SLICE; i++) begin : g_bit
        fullAdder u_fa (
            .i_a   (i_a[i]),
            .i_b   (i_b[i]),
            .i_cin (w_c[i]),
            .o_sum (o_sum[i]),
            .o_cout(w_c[i+1])
        );
    end

    assign o_cout = w_c[SLICE];

endmodule

// File: rtl/fullAdder.sv
// One-bit full adder; the leaf cell of the slice ripple chain.
module fullAdder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/sliced_adder.sv
// Multi-cycle WIDTH-bit add/subtract, SLICE bits per clock, with N/Z/C/V flags.
// Define SLICED_ADDER_FLAGS_EN to compute overflow/zero/negative; otherwise they read 0.
module sliced_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SLICE = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             carryin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] K_LAST = CW'(NSLICE - 1);

    if (!slice_cfg_ok(WIDTH, SLICE)) begin : g_cfg_err
        $error("sliced_adder: WIDTH must be a positive multiple of SLICE");
    end

    adder_state_t     r_state, w_state_nxt;
    logic [CW-1:0]    r_k;
    logic [WIDTH-1:0] r_a, r_b, r_result, w_result_nxt;
    logic             r_carry;
    adder_flags_t     r_flags, w_flags_nxt;
    logic [SLICE-1:0] w_sum_slice;
    logic             w_cout_slice;

    adder_slice #(.SLICE(SLICE)) u_slice (
        .i_a   (r_a[r_k*SLICE +: SLICE]),
        .i_b   (r_b[r_k*SLICE +: SLICE]),
        .i_cin (r_carry),
        .o_sum (w_sum_slice),
        .o_cout(w_cout_slice)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = RUN;
            end
            RUN: begin
                if (r_k == K_LAST) w_state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // The final slice's flags must see the complete result, so build it before the register.
    always_comb begin
        w_result_nxt = r_result;
        w_result_nxt[r_k*SLICE +: SLICE] = w_sum_slice;
    end

    always_comb begin
        w_flags_nxt   = '0;
        w_flags_nxt.c = w_cout_slice;
`ifdef SLICED_ADDER_FLAGS_EN
        w_flags_nxt.n = w_result_nxt[WIDTH-1];
        w_flags_nxt.z = ~|w_result_nxt;
        w_flags_nxt.v = (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                        (w_result_nxt[WIDTH-1] != r_a[WIDTH-1]);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_k      <= '0;
            r_carry  <= 1'b0;
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= carryin;
                        r_k     <= '0;
                    end
                end
                RUN: begin
                    r_result <= w_result_nxt;
                    r_carry  <= w_cout_slice;
                    r_k      <= r_k + 1'b1;
                    if (r_k == K_LAST) r_flags <= w_flags_nxt;
                end
                default: ;
            endcase
        end
    end

    assign result   = r_result;
    assign carryout = r_flags.c;
    assign overflow = r_flags.v;
    assign zero     = r_flags.z;
    assign negative = r_flags.n;

endmodule

// File: tb/tb_sliced_adder.sv
// Bench for sliced_adder: directed vectors plus a transaction-level reference model.
module tb_sliced_adder;

`ifdef SLICED_ADDER_FLAGS_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif
    localparam int NS = 4;

    typedef struct packed {
        logic [63:0] res;
        logic c, v, z, n;
    } exp_t;

    logic        clk = 1'b0, reset = 1'b1;
    logic        in_valid = 1'b0, out_ready = 1'b1, sub = 1'b0, carryin = 1'b0;
    logic [63:0] a = '0, b = '0;
    logic        in_ready, out_valid, carryout, overflow, zero, negative;
    logic [63:0] result;

    logic        in_valid1 = 1'b0, out_ready1 = 1'b1;
    logic        in_ready1, out_valid1, carryout1, overflow1, zero1, negative1;
    logic [63:0] result1;

    int n_pass = 0, n_total = 0;

    sliced_adder #(.WIDTH(64), .SLICE(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .carryin(carryin),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .carryout(carryout), .overflow(overflow), .zero(zero), .negative(negative)
    );

    sliced_adder #(.WIDTH(64), .SLICE(64)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a), .b(b), .sub(sub), .carryin(carryin),
        .out_valid(out_valid1), .out_ready(out_ready1), .result(result1),
        .carryout(carryout1), .overflow(overflow1), .zero(zero1), .negative(negative1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    function automatic exp_t model(input logic [63:0] ma, input logic [63:0] mb,
                                   input logic ms, input logic mc);
        exp_t        r;
        logic [63:0] bb;
        logic [64:0] s;
        bb    = ms ? ~mb : mb;
        s     = {1'b0, ma} + {1'b0, bb} + {64'd0, mc};
        r.res = s[63:0];
        r.c   = s[64];
        r.v   = FL && (ma[63] == bb[63]) && (s[63] != ma[63]);
        r.z   = FL && (s[63:0] == 64'd0);
        r.n   = FL && s[63];
        return r;
    endfunction

    // Reference: one op at a time, result visible NS edges after acceptance.
    bit   m_idle = 1'b1;
    int   m_left = 0;
    exp_t m_out  = '0, m_pend = '0;
    bit   en_cmp = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_idle <= 1'b1;
            m_left <= 0;
            m_out  <= '0;
        end else if (m_idle) begin
            if (in_valid) begin
                m_idle <= 1'b0;
                m_left <= NS;
                m_pend <= model(a, b, sub, carryin);
            end
        end else if (m_left > 1) begin
            m_left <= m_left - 1;
        end else if (m_left == 1) begin
            m_left <= 0;
            m_out  <= m_pend;
        end else if (out_ready) begin
            m_idle <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (en_cmp) begin
            chk("mdl_in_ready", {63'd0, in_ready}, {63'd0, m_idle});
            chk("mdl_out_valid", {63'd0, out_valid}, {63'd0, (!m_idle && m_left == 0)});
            if (m_idle || m_left == 0) begin
                chk("mdl_result", result, m_out.res);
                chk("mdl_carryout", {63'd0, carryout}, {63'd0, m_out.c});
                chk("mdl_overflow", {63'd0, overflow}, {63'd0, m_out.v});
                chk("mdl_zero", {63'd0, zero}, {63'd0, m_out.z});
                chk("mdl_negative", {63'd0, negative}, {63'd0, m_out.n});
            end
        end
    end

    task automatic run_op(input logic [63:0] ta, input logic [63:0] tb, input logic ts,
                          input logic tc, input logic [63:0] er, input logic ec,
                          input logic ev, input logic ez, input logic en, input string nm);
        int lat;
        @(posedge clk); #1;
        a = ta; b = tb; sub = ts; carryin = tc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_latency"}, 64'(lat), 64'(NS));
        chk({nm, "_result"}, result, er);
        chk({nm, "_carryout"}, {63'd0, carryout}, {63'd0, ec});
        chk({nm, "_overflow"}, {63'd0, overflow}, {63'd0, ev});
        chk({nm, "_zero"}, {63'd0, zero}, {63'd0, ez});
        chk({nm, "_negative"}, {63'd0, negative}, {63'd0, en});
    endtask

    initial begin
        int lat;
        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b0;
        en_cmp = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_carryout", {63'd0, carryout}, 64'd0);
        chk("rst1_in_ready", {63'd0, in_ready1}, 64'd1);
        chk("rst1_result", result1, 64'd0);

        run_op(64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, FL, 1'b0, "add_wrap");
        run_op(64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0, FL, "sub_neg");
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000,
               1'b0, FL, 1'b0, FL, "add_ovf");

        // Backpressure: hold DONE while inputs churn.
        @(posedge clk); #1;
        out_ready = 1'b0;
        a = 64'd3; b = 64'd4; sub = 1'b0; carryin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("hold_latency", 64'(lat), 64'(NS));
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            a   = 64'(i + 1) * 64'h1111_1111;
            b   = ~a;
            sub = i[0];
            @(posedge clk); #1;
            chk("hold_result", result, 64'd7);
            chk("hold_out_valid", {63'd0, out_valid}, 64'd1);
            chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_in_ready", {63'd0, in_ready}, 64'd1);
        chk("release_out_valid", {63'd0, out_valid}, 64'd0);
        chk("release_result", result, 64'd7);

        // Reset during the second RUN cycle discards the op.
        @(posedge clk); #1;
        a = 64'h1234; b = 64'h1; sub = 1'b0; carryin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("partial_slice0", {48'd0, result[15:0]}, 64'h1235);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_result", result, 64'd0);
        chk("midrst_flags", {60'd0, carryout, overflow, zero, negative}, 64'd0);
        run_op(64'h10, 64'h20, 1'b0, 1'b0, 64'h30, 1'b0, 1'b0, 1'b0, 1'b0, "after_rst");

        // Single-slice instance: latency 1.
        @(posedge clk); #1;
        a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'h1; sub = 1'b0; carryin = 1'b0; in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        lat = 0;
        while (!out_valid1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("s64_latency", 64'(lat), 64'd1);
        chk("s64_in_ready", {63'd0, in_ready1}, 64'd0);
        chk("s64_result", result1, 64'd0);
        chk("s64_carryout", {63'd0, carryout1}, 64'd1);
        chk("s64_zero", {63'd0, zero1}, {63'd0, FL});
        chk("s64_overflow", {63'd0, overflow1}, 64'd0);
        chk("s64_negative", {63'd0, negative1}, 64'd0);

        repeat (2) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sliced_adder.md
# sliced_adder

Parametrised multi-cycle integer adder/subtractor for the datapath. It processes a WIDTH-bit operation SLICE bits per clock, with a carry register chaining the slices, and produces ARM-style N/Z/C/V flags. It sits beside the ALU for wide operands where a single-cycle ripple chain would miss timing. Valid/ready handshakes on both sides let the control unit stall on it.

## Interface
Parameters:
- WIDTH, 64, operand/result width in bits
- SLICE, 16, bits added per cycle; WIDTH % SLICE must be 0, else elaboration $error

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operation request
- in_ready  output  1  block can accept an operation
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- sub  input  1  1: compute A + ~B + carryin; 0: compute A + B + carryin
- carryin  input  1  carry into bit 0 (caller drives 1 for plain subtract)
- out_valid  output  1  result and flags valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  sum
- carryout  output  1  carry out of the MSB
- overflow  output  1  signed overflow
- zero  output  1  result == 0
- negative  output  1  result[WIDTH-1]

## Operation
- NSLICE = WIDTH/SLICE. States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch a, B' = sub ? ~b : b, and carryin into the carry register. Clear the slice counter and go to RUN.
- RUN: each cycle, add slice k of A and B' with the carry register. Write the SLICE-bit sum into result[k*SLICE +: SLICE] and update the carry register. Increment k.
- When k == NSLICE-1 completes, go to DONE. Input changes during RUN/DONE have no effect; operands are latched.
- DONE: out_valid=1. carryout = final carry. overflow = (A[msb]==B'[msb]) && (result[msb]!=A[msb]). zero and negative are derived from result.
- DONE with out_ready=1: go to IDLE. With out_ready=0: hold all outputs stable indefinitely.
- in_valid outside IDLE is ignored; there is no queueing.

## Timing
- Reset values: in_ready=1 (state IDLE), out_valid=0, result=0, carryout=0, overflow=0, zero=0, negative=0. The counter and carry register also clear.
- Latency: out_valid rises NSLICE clock edges after the accepting edge.
- Throughput: at most one operation per NSLICE+2 cycles (IDLE, NSLICE×RUN, DONE).
- in_ready and out_valid are never both 1.
- Outputs are registered. Flags are valid only while out_valid=1; otherwise they hold their last value, or the reset value.
- Reset asserted in any state: on the next edge return to IDLE with reset values and discard the operation. Reset has priority over the handshake.
- NSLICE=1 (SLICE==WIDTH): a single RUN cycle, latency 1.

## Configuration
- SLICED_ADDER_FLAGS_EN
  - Defined: overflow, zero and negative are computed as above.
  - Undefined: those three outputs are tied to 0 and their logic is removed. result, carryout and the handshakes are unaffected.

## Structure
- Shared package adder_pkg holds:
  - state enum adder_state_t {IDLE, RUN, DONE}
  - flags struct adder_flags_t {n, z, c, v}
  - the parameter-check helper
- One sub-module, adder_slice: a combinational SLICE-bit ripple of fullAdder instances with cin/cout.
- The top holds the FSM, counter, operand/carry registers and flag logic.

## Test plan
WIDTH=64 and SLICE=16 unless stated.
- A=0x1, B=0xFFFF_FFFF_FFFF_FFFF, sub=0, cin=0 -> result=0, carryout=1, zero=1, overflow=0; out_valid exactly 4 edges after accept.
- A=5, B=7, sub=1, cin=1 -> result=0xFFFF_FFFF_FFFF_FFFE, carryout=0, negative=1, overflow=0.
- A=0x7FFF_FFFF_FFFF_FFFF, B=1, add -> result=0x8000_0000_0000_0000, overflow=1, negative=1, carryout=0.
- Hold out_ready=0 for 5 cycles in DONE while toggling in_valid and the operands -> outputs stable, in_ready=0, no new op accepted; out_ready=1 -> IDLE on the next edge.
- Reset pulsed during the 2nd RUN cycle -> next cycle in_ready=1, out_valid=0, all outputs 0. A following 0x10+0x20 op returns 0x30.
- SLICE=64 instance with A=0xFFFF_FFFF_FFFF_FFFF, B=1 -> result=0, carryout=1, latency 1. Repeat with SLICED_ADDER_FLAGS_EN undefined -> zero=0, overflow=0, negative=0.
